// File: rtl/rf_arb_pkg.sv
// Shared types and requester indices for the register-file writeback arbiter.
// No logic; imported by the arbiter, its aging counters and the bench.
package rf_arb_pkg;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;
  localparam int NUM_REQ  = 3;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_wr_t;

  typedef logic [3:0] wait_cnt_t;

endpackage

// File: rtl/rf_arb_age_counter.sv
// Saturating count of consecutive lost arbitration cycles for one requester.
// Flags urgent once STARVE_LIMIT is reached; frozen while stall is high.
module rf_arb_age_counter
  import rf_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic valid,
  input  logic ready,
  output logic urgent
);

  localparam wait_cnt_t LIMIT = wait_cnt_t'(STARVE_LIMIT);

  wait_cnt_t wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!stall) begin
      if (!valid || ready) begin
        wait_cnt <= '0;
      end else if (wait_cnt != LIMIT) begin
        wait_cnt <= wait_cnt + wait_cnt_t'(1);
      end
    end
  end

  assign urgent = (wait_cnt == LIMIT);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Picks one writeback requester per cycle (urgent first, then lowest index) and
// registers its write for the next cycle; stall/reset withhold all grants.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ      = rf_arb_pkg::NUM_REQ,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [DATA_W-1:0]              wr_data,
  output logic                           write_en,
  output logic [NUM_REQ-1:0]             urgent
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   win;
  logic               hit_urgent;
  logic               hit_any;
  logic [NUM_REQ-1:0] grant;

  // Descending scans so the last match, i.e. the lowest index, wins.
  always_comb begin
    win        = '0;
    hit_urgent = 1'b0;
    hit_any    = 1'b0;
    grant      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && urgent[i]) begin
        win        = IDX_W'(i);
        hit_urgent = 1'b1;
      end
    end
    if (!hit_urgent) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          win     = IDX_W'(i);
          hit_any = 1'b1;
        end
      end
    end
    if (!stall && !reset && (hit_urgent || hit_any)) begin
      grant[win] = 1'b1;
    end
  end

  assign req_ready = grant;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
    rf_arb_age_counter #(
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_age (
      .clk   (clk),
      .reset (reset),
      .stall (stall),
      .valid (req_valid[g]),
      .ready (grant[g]),
      .urgent(urgent[g])
    );
  end

  // Writes to x0 complete the handshake but never reach the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr  <= '0;
      wr_data  <= '0;
      write_en <= 1'b0;
    end else if (|grant) begin
      wr_addr  <= req_addr[win];
      wr_data  <= req_data[win];
      write_en <= (req_addr[win] != '0);
    end else begin
      write_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed vector bench for rf_wb_arbiter: per-cycle table plus reset sequences.
module tb_rf_wb_arbiter;
  import rf_arb_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic [2:0]      req_valid;
  logic [2:0][4:0] req_addr;
  logic [2:0][31:0] req_data;
  logic [2:0]      req_ready;
  logic [4:0]      wr_addr;
  logic [31:0]     wr_data;
  logic            write_en;
  logic [2:0]      urgent;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .NUM_REQ(3), .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .write_en (write_en),
    .urgent   (urgent)
  );

  typedef struct {
    logic             stall;
    logic [2:0]       valid;
    logic [2:0][4:0]  addr;
    logic [2:0][31:0] data;
    logic [2:0]       exp_ready;
    logic [2:0]       exp_urgent;
    logic             exp_we;
    logic [4:0]       exp_addr;
    logic [31:0]      exp_data;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic row(input logic st, input logic [2:0] v,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                     input logic [2:0] er, input logic [2:0] eu,
                     input logic ew, input logic [4:0] ea, input logic [31:0] ed);
    vec_t r;
    r.stall = st;  r.valid = v;
    r.addr[REQ_ALU] = a0; r.addr[REQ_LOAD] = a1; r.addr[REQ_DBG] = a2;
    r.data[REQ_ALU] = d0; r.data[REQ_LOAD] = d1; r.data[REQ_DBG] = d2;
    r.exp_ready = er; r.exp_urgent = eu;
    r.exp_we = ew; r.exp_addr = ea; r.exp_data = ed;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic st, input logic [2:0] v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    stall = st; req_valid = v;
    req_addr[0] = a0; req_addr[1] = a1; req_addr[2] = a2;
    req_data[0] = d0; req_data[1] = d1; req_data[2] = d2;
  endtask

  initial begin
    // single request, then idle
    row(0, 3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0, 3'b001, 3'b000, 1, 5, 32'hDEADBEEF);
    row(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 5, 32'hDEADBEEF);
    // ALU every cycle against DBG: DBG ages to urgent and wins on the fifth cycle
    row(0, 3'b101, 1, 0, 9, 32'h11, 0, 32'h99, 3'b001, 3'b000, 1, 1, 32'h11);
    row(0, 3'b101, 2, 0, 9, 32'h22, 0, 32'h99, 3'b001, 3'b000, 1, 2, 32'h22);
    row(0, 3'b101, 3, 0, 9, 32'h33, 0, 32'h99, 3'b001, 3'b000, 1, 3, 32'h33);
    row(0, 3'b101, 4, 0, 9, 32'h44, 0, 32'h99, 3'b001, 3'b000, 1, 4, 32'h44);
    row(0, 3'b101, 6, 0, 9, 32'h66, 0, 32'h99, 3'b100, 3'b100, 1, 9, 32'h99);
    row(0, 3'b001, 6, 0, 0, 32'h66, 0, 0,      3'b001, 3'b000, 1, 6, 32'h66);
    row(0, 3'b101, 7, 0, 10, 32'h77, 0, 32'hA0, 3'b001, 3'b000, 1, 7, 32'h77);
    row(0, 3'b100, 0, 0, 10, 0, 0, 32'hA0,     3'b100, 3'b000, 1, 10, 32'hA0);
    // write to x0: handshake completes, write_en stays low
    row(0, 3'b010, 0, 0, 0, 0, 32'h1234, 0, 3'b010, 3'b000, 0, 0, 32'h1234);
    row(0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 3'b000, 0, 0, 32'h1234);
    // stall for three cycles with all valid; aging must freeze
    row(0, 3'b111, 1, 2, 3, 32'hA1, 32'hB2, 32'hC3, 3'b001, 3'b000, 1, 1, 32'hA1);
    row(1, 3'b111, 4, 2, 3, 32'hA4, 32'hB2, 32'hC3, 3'b000, 3'b000, 0, 1, 32'hA1);
    row(1, 3'b111, 4, 2, 3, 32'hA4, 32'hB2, 32'hC3, 3'b000, 3'b000, 0, 1, 32'hA1);
    row(1, 3'b111, 4, 2, 3, 32'hA4, 32'hB2, 32'hC3, 3'b000, 3'b000, 0, 1, 32'hA1);
    row(0, 3'b111, 4, 2, 3, 32'hA4, 32'hB2, 32'hC3, 3'b001, 3'b000, 1, 4, 32'hA4);
    row(0, 3'b111, 5, 2, 3, 32'hA5, 32'hB2, 32'hC3, 3'b001, 3'b000, 1, 5, 32'hA5);
    row(0, 3'b111, 6, 2, 3, 32'hA6, 32'hB2, 32'hC3, 3'b001, 3'b000, 1, 6, 32'hA6);
    // LOAD and DBG urgent together: lower index first, DBG next
    row(0, 3'b111, 7, 2, 3, 32'hA7, 32'hB2, 32'hC3, 3'b010, 3'b110, 1, 2, 32'hB2);
    row(0, 3'b101, 7, 0, 3, 32'hA7, 0, 32'hC3,      3'b100, 3'b100, 1, 3, 32'hC3);
    row(0, 3'b001, 7, 0, 0, 32'hA7, 0, 0,           3'b001, 3'b000, 1, 7, 32'hA7);

    // reset with a requester already valid: no grant, all outputs clear
    reset = 1'b1;
    drive(0, 3'b001, 5, 0, 0, 32'h55, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_we", write_en, 1'b0);
    chk("rst_addr", wr_addr, 5'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_urgent", urgent, 3'b000);
    reset = 1'b0;
    drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_we[%0d]", i), write_en, 1'b0);
      chk($sformatf("idle_ready[%0d]", i), req_ready, 3'b000);
    end

    foreach (tbl[k]) begin
      drive(tbl[k].stall, tbl[k].valid,
            tbl[k].addr[0], tbl[k].addr[1], tbl[k].addr[2],
            tbl[k].data[0], tbl[k].data[1], tbl[k].data[2]);
      @(negedge clk);
      chk($sformatf("v%0d_ready", k), req_ready, tbl[k].exp_ready);
      chk($sformatf("v%0d_urgent", k), urgent, tbl[k].exp_urgent);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", k), write_en, tbl[k].exp_we);
      chk($sformatf("v%0d_addr", k), wr_addr, tbl[k].exp_addr);
      chk($sformatf("v%0d_data", k), wr_data, tbl[k].exp_data);
    end

    // age LOAD and DBG to urgent, grant LOAD addr 7, then reset the next edge
    for (int i = 0; i < 4; i++) begin
      drive(0, 3'b111, 5'(i + 1), 7, 9, 32'(i + 1), 32'h77, 32'h99);
      @(negedge clk);
      chk($sformatf("age_ready[%0d]", i), req_ready, 3'b001);
      @(posedge clk);
      #1;
    end
    drive(0, 3'b111, 5'h1E, 7, 9, 32'h1E, 32'h77, 32'h99);
    @(negedge clk);
    chk("mid_urgent", urgent, 3'b110);
    chk("mid_ready", req_ready, 3'b010);
    @(posedge clk);
    #1;
    chk("mid_we", write_en, 1'b1);
    chk("mid_addr", wr_addr, 5'd7);
    reset = 1'b1;
    drive(0, 3'b101, 5'h1E, 0, 9, 32'h1E, 0, 32'h99);
    @(negedge clk);
    chk("mid_rst_ready", req_ready, 3'b000);
    @(posedge clk);
    #1;
    chk("mid_rst_we", write_en, 1'b0);
    chk("mid_rst_addr", wr_addr, 5'd0);
    chk("mid_rst_urgent", urgent, 3'b000);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_urgent", urgent, 3'b000);
    chk("post_rst_ready", req_ready, 3'b001);
    @(posedge clk);
    #1;
    chk("post_rst_we", write_en, 1'b1);
    chk("post_rst_addr", wr_addr, 5'h1E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the register file's single write port among several writeback requesters: ALU, load unit and console debug host. Each requester uses a valid/ready handshake. A fixed priority with starvation aging picks one winner per cycle, and the winning write is driven to the register file's write port through a registered stage. The block sits between the execute/memory stages and the register file write inputs.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; index 0 has highest base priority
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- STARVE_LIMIT, 4, consecutive lost cycles before a requester becomes urgent (1..15)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  freeze; no grants while high
- req_valid  in  NUM_REQ  request pending, per requester
- req_addr  in  NUM_REQ x ADDR_W  destination register, per requester
- req_data  in  NUM_REQ x DATA_W  write value, per requester
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid & ready
- wr_addr  out  ADDR_W  to register file wr_addr
- wr_data  out  DATA_W  to register file wr_data
- write_en  out  1  to register file write_en
- urgent  out  NUM_REQ  per-requester aging flag, for debug visibility

## Operation
- Each requester holds req_valid, req_addr and req_data stable from assertion until its req_ready is sampled high. req_valid must not drop before the grant.
- Arbitration is combinational every cycle:
  - If stall or reset is high, req_ready = 0.
  - Otherwise, the lowest-index valid requester with urgent set wins.
  - If no valid requester is urgent, the lowest-index valid requester wins.
  - At most one req_ready bit is high.
- Aging counter wait_cnt[i], ADDR-independent, 4 bits:
  - Increments when req_valid[i] & !req_ready[i] & !stall.
  - Saturates at STARVE_LIMIT.
  - Clears on grant or when req_valid[i] is low.
  - Holds while stall is high.
  - urgent[i] = (wait_cnt[i] == STARVE_LIMIT).
- On a grant, the output register loads wr_addr and wr_data from the winner.
  - write_en = 1 only if the granted address is not 0. A write to x0 is accepted, since the handshake completes, but dropped.
  - With no grant: write_en = 0, and wr_addr/wr_data hold their previous values.
- Reset values: write_en 0, wr_addr 0, wr_data 0, every wait_cnt 0, urgent 0, req_ready 0.

## Timing
- Grant at rising edge N (valid & ready sampled) → wr_addr, wr_data and write_en valid during cycle N+1. The register file commits at edge N+1.
- Throughput: one write per cycle. Back-to-back grants to different requesters are allowed.
- Readers see the cycle N+1 write through the register file's same-cycle bypass. The arbiter adds no forwarding.
- stall rising in cycle N: no grant at edge N. A write already in the output register, granted at N-1, still completes in cycle N.
- Reset asserted mid-operation: at the reset edge, write_en clears and any write registered for the next cycle is lost. Requesters re-present after reset.
- Simultaneous urgent requesters: the lowest index wins. The others keep urgent set and win on later cycles in index order.
- Worst-case wait for any requester under continuous contention: at most STARVE_LIMIT + NUM_REQ - 1 cycles.

## Structure
- Package rf_arb_pkg holds:
  - Localparams REQ_ALU = 0, REQ_LOAD = 1, REQ_DBG = 2, and NUM_REQ.
  - Typedef rf_wr_t, a struct with addr[4:0] and data[31:0].
  - Typedef wait_cnt_t, logic[3:0].
- Sub-module rf_arb_age_counter: one saturating aging counter plus its urgent flag, instantiated NUM_REQ times through generate.
- Top level contains the priority select, the one-hot grant, the output register and the x0 suppression.

## Test plan
- Reset then idle: all outputs 0; write_en stays 0 for 10 cycles with no valid.
- Single request: ALU valid with addr 5, data 0xDEADBEEF at edge N → req_ready[0]=1 in cycle N; wr_addr=5, wr_data=0xDEADBEEF, write_en=1 in cycle N+1; write_en=0 in N+2.
- Contention:
  - ALU valid every cycle and DBG valid (addr 9, data 0x99) from cycle 0; STARVE_LIMIT=4.
  - DBG loses 4 cycles, urgent[2]=1, then DBG is granted at cycle 4.
  - ALU is granted at cycles 0–3 and 5+.
  - wait_cnt[2] clears after the grant.
- x0 write: LOAD addr 0, data 0x1234 → req_ready[1]=1, write_en=0 next cycle; the register file is unchanged.
- Stall: stall high for 3 cycles with all three valid → no req_ready and no wait_cnt change. The write granted just before stall still appears with write_en=1. When stall drops, index 0 is granted.
- Reset mid-operation: grant LOAD addr 7 at edge N with reset high at edge N+1 → write_en=0 after that edge, and all counters and urgent flags are 0.
